// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Instruction field positions as seen by decode
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int INST_MSB = 29;
  localparam int INST_LSB = 28;
  localparam int IMM_BIT  = 27;

  function automatic word_t pc_inc(input word_t pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the fetch queue and the
// outstanding-request PC tracker. Storage is reset so outputs read as zero.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Qualify requests so the FIFO never over- or under-runs
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != FULL_C) || do_pop_s);
  end

  // Pointer, count and storage update; flush drops contents but keeps data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues word reads, tracks in-flight PCs, queues returned
// words for decode, and squashes stale responses after a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 2,
  localparam int   CW       = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_p1
);

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_e  state_r, state_s;
  word_t         pc_r, pc_s;
  logic [CW-1:0] stale_r, stale_s;
  logic          err_r, err_s;

  logic [CW-1:0] out_cnt_s;
  logic [CW-1:0] q_cnt_s;
  word_t         out_pc_s;
  logic [95:0]   q_rdata_s;
  logic [CW:0]   occ_s;
  logic          pop_s;
  logic          issue_s;
  logic          rsp_pop_s;

  assign pop_s = id_valid && id_ready;

  // Issue decision: in-flight plus queued work must leave room after this pop
  always_comb begin
    occ_s     = {1'b0, out_cnt_s} + {1'b0, q_cnt_s} - {{CW{1'b0}}, pop_s};
    issue_s   = (state_r == RUN) && !redirect_en && (occ_s < DEPTH_C);
    rsp_pop_s = imem_rvalid && (state_r == RUN) && (out_cnt_s != {CW{1'b0}});
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_en),
    .push  (issue_s),
    .wdata (pc_r),
    .pop   (rsp_pop_s),
    .rdata (out_pc_s),
    .count (out_cnt_s)
  );

  fetch_fifo #(.WIDTH(96), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_en),
    .push  (rsp_pop_s),
    .wdata ({imem_rdata, out_pc_s, pc_inc(out_pc_s)}),
    .pop   (pop_s),
    .rdata (q_rdata_s),
    .count (q_cnt_s)
  );

  // Next-state, PC, stale-count and error-flag logic
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    stale_s = stale_r;
    err_s   = err_r;
    case (state_r)
      BOOT: begin
        state_s = RUN;
        if (redirect_en) begin
          pc_s = redirect_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem_rvalid) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
      end
      RUN: begin
        if (imem_rvalid && !rsp_pop_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (redirect_en) begin
          // A response landing this cycle is already consumed, so it is not stale
          pc_s    = redirect_pc;
          stale_s = out_cnt_s - CW'(rsp_pop_s);
          if (stale_s != {CW{1'b0}}) begin
            state_s = DRAIN;
          end else begin
            state_s = RUN;
          end
        end else if (issue_s) begin
          pc_s = pc_inc(pc_r);
        end else begin
          pc_s = pc_r;
        end
      end
      DRAIN: begin
        if (redirect_en) begin
          pc_s = redirect_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem_rvalid && (stale_r != {CW{1'b0}})) begin
          stale_s = stale_r - CW'(1);
        end else if (imem_rvalid) begin
          err_s = 1'b1;
        end else begin
          stale_s = stale_r;
        end
        if (stale_s == {CW{1'b0}}) begin
          state_s = RUN;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
      stale_r <= {CW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      stale_r <= stale_s;
      err_r   <= err_s;
    end
  end

  assign imem_req  = issue_s;
  assign imem_addr = pc_r;
  assign id_valid  = (q_cnt_s != {CW{1'b0}});
  assign {id_instr, id_pc, id_pc_p1} = q_rdata_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with adjustable
// latency, hand-computed per-cycle expectations.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_p1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [31:0] p_addr [$];
  int          p_due  [$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_p1    (id_pc_p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // Record this cycle's request, cross the edge, then drive any due response
  task automatic tick();
    #1;
    if (imem_req === 1'b1) begin
      p_addr.push_back(imem_addr);
      p_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    if (p_due.size() > 0 && p_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(p_addr[0]);
      void'(p_addr.pop_front());
      void'(p_due.pop_front());
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr,         32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr,          32'd0);
    chk({tag, "_pc"},    id_pc,             32'd0);
    chk({tag, "_pcp1"},  id_pc_p1,          32'd0);
  endtask

  initial begin
    rst = 1'b0; id_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    #2;
    chk_reset("rst0");
    rst = 1'b1;

    // Sequential fetch with 1-cycle memory
    tick(); settle();                                   // c1
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    chk("c1_valid", {31'd0, id_valid}, 32'd0);
    tick(); settle();                                   // c2
    chk("c2_addr", imem_addr, 32'd1);
    chk("c2_valid", {31'd0, id_valid}, 32'd0);
    tick(); settle();                                   // c3
    chk("c3_valid", {31'd0, id_valid}, 32'd1);
    chk("c3_pc", id_pc, 32'd0);
    chk("c3_pcp1", id_pc_p1, 32'd1);
    chk("c3_instr", id_instr, 32'hA500_0000);
    chk("c3_addr", imem_addr, 32'd2);
    tick(); settle();                                   // c4
    chk("c4_pc", id_pc, 32'd1);
    chk("c4_addr", imem_addr, 32'd3);
    tick(); settle();                                   // c5
    chk("c5_pc", id_pc, 32'd2);

    // Backpressure for four cycles
    tick(); id_ready = 1'b0; settle();                  // c6
    chk("c6_req", {31'd0, imem_req}, 32'd0);
    chk("c6_pc", id_pc, 32'd3);
    tick(); tick(); tick(); settle();                   // c9
    chk("c9_req", {31'd0, imem_req}, 32'd0);
    chk("c9_pc", id_pc, 32'd3);
    chk("c9_instr", id_instr, 32'hA500_0003);
    tick(); id_ready = 1'b1; settle();                  // c10
    chk("c10_pc", id_pc, 32'd3);
    chk("c10_req", {31'd0, imem_req}, 32'd1);
    chk("c10_addr", imem_addr, 32'd5);
    tick(); settle(); chk("c11_pc", id_pc, 32'd4);
    tick(); settle(); chk("c12_pc", id_pc, 32'd5);
    tick(); settle(); chk("c13_pc", id_pc, 32'd6);
    tick(); tick(); tick(); settle();                   // c16

    // Redirect coinciding with the handshake of pc 9
    chk("c16_pc", id_pc, 32'd9);
    redirect_en = 1'b1; redirect_pc = 32'h20; settle();
    chk("c16_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_en = 1'b0; settle();               // c17
    chk("c17_valid", {31'd0, id_valid}, 32'd0);
    chk("c17_addr", imem_addr, 32'h20);
    chk("c17_req", {31'd0, imem_req}, 32'd1);
    tick(); settle();                                   // c18
    chk("c18_valid", {31'd0, id_valid}, 32'd0);
    tick(); settle();                                   // c19
    chk("c19_pc", id_pc, 32'h20);
    chk("c19_instr", id_instr, 32'hA500_0020);

    // Redirect to the top of the address space
    tick(); redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF; settle();  // c20
    tick(); redirect_en = 1'b0; settle();               // c21
    chk("c21_addr", imem_addr, 32'hFFFF_FFFF);
    tick(); settle();                                   // c22
    chk("c22_addr", imem_addr, 32'd0);
    tick(); settle();                                   // c23
    chk("c23_pc", id_pc, 32'hFFFF_FFFF);
    chk("c23_pcp1", id_pc_p1, 32'd0);
    tick(); settle();                                   // c24
    chk("c24_pc", id_pc, 32'd0);
    chk("c24_pcp1", id_pc_p1, 32'd1);

    // Three-cycle memory, redirect with two responses in flight
    tick(); lat = 3; settle();                          // c25
    tick(); tick(); redirect_en = 1'b1; redirect_pc = 32'h40; settle();  // c27
    chk("c27_valid", {31'd0, id_valid}, 32'd0);
    chk("c27_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_en = 1'b0; settle();               // c28
    chk("c28_rv", {31'd0, imem_rvalid}, 32'd1);
    chk("c28_req", {31'd0, imem_req}, 32'd0);
    tick(); settle();                                   // c29
    chk("c29_rv", {31'd0, imem_rvalid}, 32'd1);
    chk("c29_req", {31'd0, imem_req}, 32'd0);
    chk("c29_valid", {31'd0, id_valid}, 32'd0);
    tick(); settle();                                   // c30
    chk("c30_req", {31'd0, imem_req}, 32'd1);
    chk("c30_addr", imem_addr, 32'h40);
    tick(); tick(); tick(); settle();                   // c33
    chk("c33_valid", {31'd0, id_valid}, 32'd0);
    tick(); settle();                                   // c34
    chk("c34_pc", id_pc, 32'h40);
    chk("c34_instr", id_instr, 32'hA500_0040);

    // Enter DRAIN again, then reset in the middle of it
    tick(); redirect_en = 1'b1; redirect_pc = 32'h80; settle();  // c35
    chk("c35_pc", id_pc, 32'h41);
    tick(); redirect_en = 1'b0; settle();               // c36
    chk("c36_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk_reset("rst1");
    p_addr.delete(); p_due.delete();
    lat = 1;
    tick(); rst = 1'b1; settle();                       // BOOT
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    tick(); settle();
    chk("r1_req", {31'd0, imem_req}, 32'd1);
    chk("r1_addr", imem_addr, 32'd0);
    tick(); settle();
    chk("r2_addr", imem_addr, 32'd1);
    tick(); settle();
    chk("r3_pc", id_pc, 32'd0);
    chk("r3_instr", id_instr, 32'hA500_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
